// File: rtl/dht_pkg.sv
// Shared definitions for the multi-channel DHT poller.
// Contents:
//   state_t        - poller FSM state encoding
//   *_LSB          - bit offsets of each byte in the 40-bit sensor frame
//   frame_byte()   - extracts one byte of a frame at a given offset
package dht_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CHECK   = 3'd3,
    ADVANCE = 3'd4
  } state_t;

  localparam int FRAME_W    = 40;
  localparam int HUM_HI_LSB = 32;
  localparam int HUM_LO_LSB = 24;
  localparam int TMP_HI_LSB = 16;
  localparam int TMP_LO_LSB = 8;
  localparam int SUM_LSB    = 0;

  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame, input int lsb);
    return frame[lsb +: 8];
  endfunction

endpackage

// File: rtl/dht_frame_decode.sv
// Combinational decode of one raw DHT frame.
// Ports:
//   core_data in  40  raw frame {hum_hi,hum_lo,tmp_hi,tmp_lo,sum}
//   hum       out 16  humidity x10, unsigned
//   temp      out 16  temperature x10, two's complement
//   ok        out 1   checksum matches
module dht_frame_decode
  import dht_pkg::*;
(
  input  logic [FRAME_W-1:0] core_data,
  output logic [15:0]        hum,
  output logic [15:0]        temp,
  output logic               ok
);

  logic [7:0]  w_hum_hi;
  logic [7:0]  w_hum_lo;
  logic [7:0]  w_tmp_hi;
  logic [7:0]  w_tmp_lo;
  logic [7:0]  w_sum;
  logic [15:0] w_mag;

  always_comb begin
    w_hum_hi = frame_byte(core_data, HUM_HI_LSB);
    w_hum_lo = frame_byte(core_data, HUM_LO_LSB);
    w_tmp_hi = frame_byte(core_data, TMP_HI_LSB);
    w_tmp_lo = frame_byte(core_data, TMP_LO_LSB);
    // 8-bit accumulation: carries out of the byte are intentionally lost.
    w_sum    = w_hum_hi + w_hum_lo + w_tmp_hi + w_tmp_lo;
    ok       = (w_sum == frame_byte(core_data, SUM_LSB));
    hum      = {w_hum_hi, w_hum_lo};
    // The sensor sends sign-magnitude; bit 7 of tmp_hi is the sign.
    w_mag    = {1'b0, w_tmp_hi[6:0], w_tmp_lo};
    temp     = w_tmp_hi[7] ? (16'd0 - w_mag) : w_mag;
  end

endmodule

// File: rtl/dht_multi_poller.sv
// Round-robin poller sharing one DHT sensor core between N_CH channels.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   enable, trigger      periodic polling enable, one-cycle immediate-round request
//   core_sel/core_go     channel routed to the core, one-cycle start pulse
//   core_done/core_data  completion pulse and raw 40-bit frame from the core
//   rd_ch -> rd_hum/rd_temp/rd_valid/rd_errs   registered per-channel read port
//   upd/upd_ch           one-cycle pulse and channel whenever an entry is written
//   busy                 FSM is not IDLE
module dht_multi_poller
  import dht_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CLK_HZ     = 25000000,
  parameter int POLL_MS    = 2000,
  parameter int TIMEOUT_MS = 10,
  parameter int MAX_RETRY  = 2,
  localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               trigger,
  output logic [CHW-1:0]     core_sel,
  output logic               core_go,
  input  logic               core_done,
  input  logic [FRAME_W-1:0] core_data,
  input  logic [CHW-1:0]     rd_ch,
  output logic [15:0]        rd_hum,
  output logic [15:0]        rd_temp,
  output logic               rd_valid,
  output logic [7:0]         rd_errs,
  output logic               upd,
  output logic [CHW-1:0]     upd_ch,
  output logic               busy
);

  localparam longint PER_RAW = longint'(POLL_MS) * longint'(CLK_HZ) / 1000;
  localparam longint TMO_RAW = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 1000;
  localparam longint PER_C   = (PER_RAW > 0) ? PER_RAW : 1;
  localparam longint TMO_C   = (TMO_RAW > 0) ? TMO_RAW : 1;
  localparam int     PER_W   = (PER_C > 1) ? $clog2(PER_C) : 1;
  localparam int     TMO_W   = (TMO_C > 1) ? $clog2(TMO_C) : 1;
  localparam int     ATT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               r_state, w_state_next;
  logic [CHW-1:0]       r_ch;
  logic [PER_W-1:0]     r_per_cnt;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [ATT_W-1:0]     r_attempt;
  logic                 r_trig_pend;
  logic                 r_timed_out;
  logic [FRAME_W-1:0]   r_frame;
  logic                 r_upd;
  logic [CHW-1:0]       r_upd_ch;
  logic [15:0]          r_hum   [N_CH];
  logic [15:0]          r_temp  [N_CH];
  logic                 r_valid [N_CH];
  logic [7:0]           r_errs  [N_CH];
  logic [15:0]          r_rd_hum, r_rd_temp;
  logic                 r_rd_valid;
  logic [7:0]           r_rd_errs;

  logic        w_per_exp, w_tmo_exp, w_last, w_start_req;
  logic        w_round_start, w_go, w_wr_pass, w_wr_fail, w_fail, w_retry;
  logic [15:0] w_hum, w_temp;
  logic        w_ok;

  dht_frame_decode u_decode (
    .core_data (r_frame),
    .hum       (w_hum),
    .temp      (w_temp),
    .ok        (w_ok)
  );

  assign w_per_exp   = (r_per_cnt == PER_W'(PER_C - 1));
  assign w_tmo_exp   = (r_tmo_cnt == TMO_W'(TMO_C - 1));
  assign w_last      = (r_ch == CHW'(N_CH - 1));
  assign w_start_req = trigger || r_trig_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_round_start = 1'b0;
    w_go          = 1'b0;
    w_wr_pass     = 1'b0;
    w_wr_fail     = 1'b0;
    w_fail        = 1'b0;
    w_retry       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_req || (enable && w_per_exp)) begin
          w_state_next  = ISSUE;
          w_round_start = 1'b1;
        end
      end
      ISSUE: begin
        w_go         = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (core_done || w_tmo_exp) w_state_next = CHECK;
      end
      CHECK: begin
        if (!r_timed_out && w_ok) begin
          w_wr_pass    = 1'b1;
          w_state_next = ADVANCE;
        end else begin
          w_fail = 1'b1;
          if (r_attempt < ATT_W'(MAX_RETRY)) begin
            w_retry      = 1'b1;
            w_state_next = ISSUE;
          end else begin
            w_wr_fail    = 1'b1;
            w_state_next = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        // A trigger that arrived during the round chains straight into a new one.
        if (!w_last) begin
          w_state_next = ISSUE;
        end else if (w_start_req) begin
          w_state_next  = ISSUE;
          w_round_start = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch        <= '0;
      r_per_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_attempt   <= '0;
      r_trig_pend <= 1'b0;
      r_timed_out <= 1'b0;
      r_frame     <= '0;
      r_upd       <= 1'b0;
      r_upd_ch    <= '0;
    end else begin
      // Free-running period counter, re-phased at every round start.
      if (w_round_start || w_per_exp) r_per_cnt <= '0;
      else                            r_per_cnt <= r_per_cnt + PER_W'(1);

      if (w_round_start)  r_trig_pend <= 1'b0;
      else if (trigger)   r_trig_pend <= 1'b1;

      if (r_state == ISSUE)     r_tmo_cnt <= '0;
      else if (r_state == WAIT) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (r_state == WAIT) begin
        if (core_done) begin
          r_frame     <= core_data;
          r_timed_out <= 1'b0;
        end else if (w_tmo_exp) begin
          r_timed_out <= 1'b1;
        end
      end

      if (r_state == ADVANCE) r_attempt <= '0;
      else if (w_retry)       r_attempt <= r_attempt + ATT_W'(1);

      if (r_state == ADVANCE) r_ch <= w_last ? '0 : r_ch + CHW'(1);

      r_upd    <= w_wr_pass || w_wr_fail;
      r_upd_ch <= r_ch;
    end
  end

  // Channel table plus its registered read port. The read samples the
  // table before this cycle's write lands, giving pre-write data on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_hum[i]   <= '0;
        r_temp[i]  <= '0;
        r_valid[i] <= 1'b0;
        r_errs[i]  <= '0;
      end
      r_rd_hum   <= '0;
      r_rd_temp  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_errs  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_ch == CHW'(i)) begin
          if (w_wr_pass) begin
            r_hum[i]   <= w_hum;
            r_temp[i]  <= w_temp;
            r_valid[i] <= 1'b1;
          end
          if (w_wr_fail) r_valid[i] <= 1'b0;
          if (w_fail && (r_errs[i] != 8'hFF)) r_errs[i] <= r_errs[i] + 8'd1;
        end
      end
      r_rd_hum   <= '0;
      r_rd_temp  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_errs  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (rd_ch == CHW'(i)) begin
          r_rd_hum   <= r_hum[i];
          r_rd_temp  <= r_temp[i];
          r_rd_valid <= r_valid[i];
          r_rd_errs  <= r_errs[i];
        end
      end
    end
  end

  assign core_sel = r_ch;
  assign core_go  = w_go;
  assign busy     = (r_state != IDLE);
  assign upd      = r_upd;
  assign upd_ch   = r_upd_ch;
  assign rd_hum   = r_rd_hum;
  assign rd_temp  = r_rd_temp;
  assign rd_valid = r_rd_valid;
  assign rd_errs  = r_rd_errs;

endmodule
